// File: rtl/floo_vc_pkg.sv
// -----------------------------------------------------------------------------
// floo_vc_pkg
// Shared types and defaults for the credit-based VC link. Both the VC output
// port (transmit side) and the VC input port (receive side) import this
// package, so both ends agree on the VC id width, the default per-VC buffer
// depth and the default link flit layout.
// -----------------------------------------------------------------------------
package floo_vc_pkg;

    // Default link geometry.
    localparam int unsigned NumVcDefault   = 4;
    localparam int unsigned VcIdWidth      = 2;
    localparam int unsigned VCDepthDefault = 3;
    localparam int unsigned CntWidthDefault = $clog2(VCDepthDefault + 1);

    // VC identifier carried in every flit header and on the credit return.
    typedef logic [VcIdWidth-1:0] vc_id_t;

    // Credit counter value for the default depth (0 .. VCDepthDefault).
    typedef logic [CntWidthDefault-1:0] credit_cnt_t;

    // Default link flit: header with the VC id plus a payload word.
    typedef struct packed {
        vc_id_t vc_id;
    } hdr_t;

    typedef struct packed {
        hdr_t        hdr;
        logic [31:0] payload;
    } flit_t;

endpackage : floo_vc_pkg

// File: rtl/floo_credit_counter.sv
// -----------------------------------------------------------------------------
// floo_credit_counter
// Credit counter for one downstream VC buffer. Starts full (Depth credits),
// decrements when a flit is sent, increments when a credit comes back.
// A credit returned while the counter is already full saturates and raises a
// sticky error that only reset clears.
//
// Ports
//   clk_i   clock
//   rst_i   synchronous active-high reset (restores Depth credits, clears err)
//   inc_i   credit returned on this VC
//   dec_i   flit sent on this VC (only asserted when a credit is usable)
//   cnt_o   registered credit count
//   err_o   sticky credit overflow flag
// -----------------------------------------------------------------------------
module floo_credit_counter #(
    parameter int unsigned Depth    = 3,
    parameter int unsigned CntWidth = $clog2(Depth + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                inc_i,
    input  logic                dec_i,
    output logic [CntWidth-1:0] cnt_o,
    output logic                err_o
);

    localparam logic [CntWidth-1:0] CntFull = CntWidth'(Depth);
    localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);

    logic [CntWidth-1:0] cnt_d, cnt_q;
    logic                err_d, err_q;
    logic                full, empty;

    assign full  = (cnt_q == CntFull);
    assign empty = (cnt_q == '0);

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave it unassigned and infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        unique case ({inc_i, dec_i})
            2'b10: begin
                // A credit at full means the downstream returned more than it
                // was given; hold the count and flag it.
                if (full) err_d = 1'b1;
                else      cnt_d = cnt_q + CntOne;
            end
            2'b01: begin
                // Guarded anyway: the port never sends without a credit.
                if (!empty) cnt_d = cnt_q - CntOne;
            end
            2'b11: begin
                // Credit and send cancel out.
                if (full) err_d = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values seen before the edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= CntFull;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign cnt_o = cnt_q;
    assign err_o = err_q;

endmodule : floo_credit_counter

// File: rtl/floo_vc_output_port.sv
// -----------------------------------------------------------------------------
// floo_vc_output_port
// Transmit end of the credit-based VC link. Granted flits from switch
// traversal are registered onto the link with one cycle of latency. One
// credit counter per downstream VC buffer throttles the link; per-VC credit
// availability is reported back to switch/VC allocation.
//
// Ports
//   clk_i              clock
//   rst_i              synchronous active-high reset
//   valid_i            flit from ST stage is valid
//   ready_o            flit accepted this cycle (valid_i & ready_o)
//   data_i             flit from ST stage
//   data_v_o           link flit valid
//   data_o             link flit
//   credit_v_i         credit returned by the downstream input port
//   credit_id_i        VC of the returned credit
//   vc_credit_avail_o  per-VC: at least one usable credit
//   credit_err_o       sticky: credit returned while a counter was full
//
// Configuration
//   FLOO_VC_OUTPUT_CREDIT_BYPASS_EN  when defined, a credit arriving this
//   cycle is usable this cycle (combinational credit_v_i -> ready_o path).
//   When undefined, a returned credit is first usable the next cycle.
// -----------------------------------------------------------------------------
module floo_vc_output_port
    import floo_vc_pkg::*;
#(
    parameter type         flit_t     = floo_vc_pkg::flit_t,
    parameter int unsigned NumVC      = NumVcDefault,
    parameter int unsigned NumVCWidth = VcIdWidth,
    parameter int unsigned VCDepth    = VCDepthDefault,
    parameter int unsigned CntWidth   = $clog2(VCDepth + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  flit_t                 data_i,
    output logic                  data_v_o,
    output flit_t                 data_o,
    input  logic                  credit_v_i,
    input  logic [NumVCWidth-1:0] credit_id_i,
    output logic [NumVC-1:0]      vc_credit_avail_o,
    output logic                  credit_err_o
);

    logic [NumVCWidth-1:0] vc_id;
    logic [CntWidth-1:0]   cnt [NumVC];
    logic [NumVC-1:0]      cnt_nz;
    logic [NumVC-1:0]      credit_hit;
    logic [NumVC-1:0]      usable;
    logic [NumVC-1:0]      send;
    logic [NumVC-1:0]      err_vc;
    logic                  accept;

    assign vc_id = data_i.hdr.vc_id;

    // Per-VC decode of the returned credit and of the outgoing flit.
    always_comb begin
        credit_hit = '0;
        send       = '0;
        for (int v = 0; v < NumVC; v++) begin
            credit_hit[v] = credit_v_i && (credit_id_i == NumVCWidth'(v));
            send[v]       = accept && (vc_id == NumVCWidth'(v));
        end
    end

`ifdef FLOO_VC_OUTPUT_CREDIT_BYPASS_EN
    // A credit arriving now may be spent now.
    assign usable = cnt_nz | credit_hit;
`else
    // Availability comes purely from the registered counters.
    assign usable = cnt_nz;
`endif

    // ready_o depends only on the flit's VC, never on valid_i. An id outside
    // 0..NumVC-1 matches no VC and is therefore never accepted.
    always_comb begin
        ready_o = 1'b0;
        for (int v = 0; v < NumVC; v++) begin
            if ((vc_id == NumVCWidth'(v)) && usable[v]) ready_o = 1'b1;
        end
    end

    assign accept = valid_i && ready_o;

    for (genvar v = 0; v < NumVC; v++) begin : g_vc
        floo_credit_counter #(
            .Depth    (VCDepth),
            .CntWidth (CntWidth)
        ) i_credit_counter (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .inc_i (credit_hit[v]),
            .dec_i (send[v]),
            .cnt_o (cnt[v]),
            .err_o (err_vc[v])
        );
        assign cnt_nz[v] = (cnt[v] != '0);
    end

    assign vc_credit_avail_o = usable;
    assign credit_err_o      = |err_vc;

    // Link register: no backpressure on the link, so an accepted flit always
    // goes out on the next cycle. data_o holds its value when idle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_v_o <= 1'b0;
            data_o   <= '0;
        end else begin
            data_v_o <= accept;
            if (accept) data_o <= data_i;
        end
    end

endmodule : floo_vc_output_port

// File: tb/tb_floo_vc_output_port.sv
// -----------------------------------------------------------------------------
// tb_floo_vc_output_port
// Directed testbench for floo_vc_output_port with NumVC=4, VCDepth=3.
// Inputs change 1 time unit after the rising edge; outputs are sampled
// before the next rising edge.
// -----------------------------------------------------------------------------
module tb_floo_vc_output_port;
    import floo_vc_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    flit_t       data_i;
    logic        data_v_o;
    flit_t       data_o;
    logic        credit_v_i;
    logic [1:0]  credit_id_i;
    logic [3:0]  vc_credit_avail_o;
    logic        credit_err_o;

    int checks = 0;
    int errors = 0;

    floo_vc_output_port #(
        .flit_t     (flit_t),
        .NumVC      (4),
        .NumVCWidth (2),
        .VCDepth    (3)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .valid_i           (valid_i),
        .ready_o           (ready_o),
        .data_i            (data_i),
        .data_v_o          (data_v_o),
        .data_o            (data_o),
        .credit_v_i        (credit_v_i),
        .credit_id_i       (credit_id_i),
        .vc_credit_avail_o (vc_credit_avail_o),
        .credit_err_o      (credit_err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic flit_t mk(input logic [1:0] vc, input logic [31:0] pl);
        flit_t f;
        f.hdr.vc_id = vc;
        f.payload   = pl;
        return f;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present a flit (combinational ready check), clock it, then check it on the link.
    task automatic send_ok(input string name, input flit_t f);
        valid_i = 1'b1;
        data_i  = f;
        #1;
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL %s ready: got %b expected 1", name, ready_o);
        end
        tick();
        valid_i = 1'b0;
        checks++;
        if (data_v_o !== 1'b1 || data_o !== f) begin
            errors++;
            $display("FAIL %s link: got v=%b d=%h expected v=1 d=%h", name, data_v_o, data_o, f);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; valid_i = 1'b0; data_i = '0; credit_v_i = 1'b0; credit_id_i = '0;
        tick(); tick();
        rst_i = 1'b0;
        #1;
        checks++;
        if (vc_credit_avail_o !== 4'b1111) begin
            errors++; $display("FAIL reset_avail: got %b expected 1111", vc_credit_avail_o);
        end
        checks++;
        if (data_v_o !== 1'b0 || data_o !== '0) begin
            errors++; $display("FAIL reset_link: got v=%b d=%h expected v=0 d=0", data_v_o, data_o);
        end
        checks++;
        if (credit_err_o !== 1'b0) begin
            errors++; $display("FAIL reset_err: got %b expected 0", credit_err_o);
        end
    endtask

    task automatic test_back_to_back();
        flit_t last;
        for (int i = 0; i < 3; i++) send_ok("b2b_vc1", mk(2'd1, 32'hA000_0000 + i));
        last = mk(2'd1, 32'hA000_0002);
        checks++;
        if (vc_credit_avail_o !== 4'b1101) begin
            errors++; $display("FAIL b2b_avail: got %b expected 1101", vc_credit_avail_o);
        end
        // Fourth flit on VC1 must be refused.
        valid_i = 1'b1;
        data_i  = mk(2'd1, 32'hA000_0003);
        #1;
        checks++;
        if (ready_o !== 1'b0) begin
            errors++; $display("FAIL b2b_vc1_blocked: got %b expected 0", ready_o);
        end
        tick();
        valid_i = 1'b0;
        checks++;
        if (data_v_o !== 1'b0 || data_o !== last) begin
            errors++; $display("FAIL b2b_idle_hold: got v=%b d=%h expected v=0 d=%h", data_v_o, data_o, last);
        end
        send_ok("b2b_vc2", mk(2'd2, 32'hB000_0000));
        checks++;
        if (vc_credit_avail_o !== 4'b1101) begin
            errors++; $display("FAIL b2b_avail2: got %b expected 1101", vc_credit_avail_o);
        end
    endtask

    task automatic test_credit_return();
        valid_i     = 1'b0;
        data_i      = mk(2'd1, 32'hC000_0000);
        credit_v_i  = 1'b1;
        credit_id_i = 2'd1;
        #1;
        checks++;
`ifdef FLOO_VC_OUTPUT_CREDIT_BYPASS_EN
        if (ready_o !== 1'b1) begin
            errors++; $display("FAIL credit_same_cycle: got %b expected 1", ready_o);
        end
`else
        if (ready_o !== 1'b0) begin
            errors++; $display("FAIL credit_same_cycle: got %b expected 0", ready_o);
        end
`endif
        tick();
        credit_v_i = 1'b0;
        #1;
        checks++;
        if (ready_o !== 1'b1 || vc_credit_avail_o !== 4'b1111) begin
            errors++; $display("FAIL credit_next_cycle: got rdy=%b avail=%b expected rdy=1 avail=1111",
                               ready_o, vc_credit_avail_o);
        end
    endtask

    task automatic test_send_and_credit();
        send_ok("sc_first", mk(2'd0, 32'hD000_0000));   // VC0: 3 -> 2
        credit_v_i  = 1'b1;
        credit_id_i = 2'd0;
        send_ok("sc_both", mk(2'd0, 32'hD000_0001));    // VC0 stays 2
        credit_v_i  = 1'b0;
        send_ok("sc_drain0", mk(2'd0, 32'hD000_0002));  // 2 -> 1
        send_ok("sc_drain1", mk(2'd0, 32'hD000_0003));  // 1 -> 0
        valid_i = 1'b1;
        data_i  = mk(2'd0, 32'hD000_0004);
        #1;
        checks++;
        if (ready_o !== 1'b0 || vc_credit_avail_o[0] !== 1'b0) begin
            errors++; $display("FAIL sc_empty: got rdy=%b avail0=%b expected 0 0", ready_o, vc_credit_avail_o[0]);
        end
        valid_i = 1'b0;
        tick();
    endtask

    task automatic test_credit_overflow();
        credit_v_i  = 1'b1;
        credit_id_i = 2'd3;
        tick();
        credit_v_i = 1'b0;
        checks++;
        if (credit_err_o !== 1'b1) begin
            errors++; $display("FAIL ovf_err: got %b expected 1", credit_err_o);
        end
        tick(); tick();
        checks++;
        if (credit_err_o !== 1'b1) begin
            errors++; $display("FAIL ovf_err_sticky: got %b expected 1", credit_err_o);
        end
        for (int i = 0; i < 3; i++) send_ok("ovf_vc3", mk(2'd3, 32'hE000_0000 + i));
        data_i = mk(2'd3, 32'hE000_0003);
        #1;
        checks++;
        if (ready_o !== 1'b0) begin
            errors++; $display("FAIL ovf_cnt_sat: got rdy=%b expected 0", ready_o);
        end
    endtask

    task automatic test_reset_mid();
        send_ok("rm_vc2_a", mk(2'd2, 32'hF000_0000));   // VC2: 2 -> 1
        send_ok("rm_vc2_b", mk(2'd2, 32'hF000_0001));   // VC2: 1 -> 0, flit on link
        checks++;
        if (vc_credit_avail_o[2] !== 1'b0) begin
            errors++; $display("FAIL rm_vc2_empty: got %b expected 0", vc_credit_avail_o[2]);
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        checks++;
        if (data_v_o !== 1'b0 || vc_credit_avail_o !== 4'b1111 || credit_err_o !== 1'b0) begin
            errors++; $display("FAIL rm_after_reset: got v=%b avail=%b err=%b expected 0 1111 0",
                               data_v_o, vc_credit_avail_o, credit_err_o);
        end
        for (int i = 0; i < 3; i++) send_ok("rm_vc2_refill", mk(2'd2, 32'hF100_0000 + i));
        checks++;
        if (vc_credit_avail_o !== 4'b1011) begin
            errors++; $display("FAIL rm_final_avail: got %b expected 1011", vc_credit_avail_o);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_credit_return();
        test_send_and_credit();
        test_credit_overflow();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_floo_vc_output_port
